// File: rtl/puf_pkg.sv
// puf_pkg -- shared definitions for the ring-oscillator PUF evaluation controller.
//
// Contents:
//   state_t     : evaluation sequencer states
//   CLR_CYC     : counter-clear duration in clk cycles
//   SETTLE_CYC  : post-window settle duration before the counts are sampled
//   MAJ_RUNS    : repeat count per pair when PUF_MAJORITY_EN is defined
//   pidx_w()    : width of the pair index, able to hold 0..RESP_BITS
//   tmr_w()     : width of the window timer, able to hold the longest duration
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam int CLR_CYC    = 2;
   localparam int SETTLE_CYC = 4;
   localparam int MAJ_RUNS   = 3;

   function automatic int pidx_w(input int resp_bits);
      return $clog2(resp_bits + 1);
   endfunction

   function automatic int tmr_w(input int win_cycles);
      int longest;
      longest = (win_cycles > SETTLE_CYC) ? win_cycles : SETTLE_CYC;
      return $clog2(longest + 1);
   endfunction

endpackage

// File: rtl/puf_win_timer.sv
// puf_win_timer -- loadable down-counter with a terminal pulse.
//
// Loading N makes tc high during the N-th cycle after the load edge, so a
// state entered on the load edge lasts exactly N cycles when it leaves on tc.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous reset, active-high
//   load     : load load_val on this edge (takes priority over counting)
//   load_val : duration in cycles (>= 1)
//   tc       : terminal-count pulse, high in the last cycle of the duration
module puf_win_timer #(
   parameter int W = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cnt_reg <= '0;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign tc = (cnt_reg == W'(1));

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl -- evaluation sequencer for the ring-oscillator PUF.
//
// For each of RESP_BITS challenge pairs: clear the bank counters, gate the
// oscillators for WIN_CYCLES, let the counts settle, then compare them and
// shift the result into the response word (pair 0 ends up at the MSB).
//
// Build option: PUF_MAJORITY_EN -- each pair is measured MAJ_RUNS times and
// the response bit is the majority of the comparisons.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous reset, active-high
//   start      : begin an evaluation (sampled only in IDLE)
//   chal_base  : base challenge, latched on an accepted start
//   count_a/b  : bank edge counts, static whenever they are sampled
//   osc_en     : oscillator gate to both banks
//   cnt_clr    : counter clear to both banks
//   chal_a/b   : bank oscillator selects for the current pair
//   busy       : evaluation in progress
//   resp       : response word, updated on resp_valid
//   resp_valid : one-cycle pulse when resp updates
//   tie_seen   : some comparison in the current/last evaluation was equal
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int CHAL_W     = 4,
   parameter int RESP_BITS  = 8,
   parameter int WIN_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAL_W-1:0]    chal_base,
   input  logic [CNT_W-1:0]     count_a,
   input  logic [CNT_W-1:0]     count_b,
   output logic                 osc_en,
   output logic                 cnt_clr,
   output logic [CHAL_W-1:0]    chal_a,
   output logic [CHAL_W-1:0]    chal_b,
   output logic                 busy,
   output logic [RESP_BITS-1:0] resp,
   output logic                 resp_valid,
   output logic                 tie_seen
);

   localparam int IW = pidx_w(RESP_BITS);
   localparam int TW = tmr_w(WIN_CYCLES);

   state_t                state_reg;
   logic [IW-1:0]         pair_reg;
   logic [RESP_BITS-1:0]  resp_sr_reg;
   logic [RESP_BITS-1:0]  resp_reg;
   logic [CHAL_W-1:0]     chal_a_reg;
   logic [CHAL_W-1:0]     chal_b_reg;
   logic                  osc_en_reg;
   logic                  cnt_clr_reg;
   logic                  busy_reg;
   logic                  resp_valid_reg;
   logic                  tie_seen_reg;

`ifdef PUF_MAJORITY_EN
   logic [1:0]            rep_reg;    // run index within the current pair
   logic [1:0]            ones_reg;   // a>b results from earlier runs of the pair
   logic [1:0]            votes;
`endif

   logic                  tmr_load;
   logic [TW-1:0]         tmr_val;
   logic                  tmr_tc;

   logic                  cmp_gt;
   logic                  cmp_eq;
   logic                  pair_done;    // this capture finishes the current pair
   logic                  pair_bit;     // response bit for the current pair
   logic                  last_capture; // this capture finishes the evaluation

   puf_win_timer #(
      .W        (TW)
   ) u_win_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   // Counts are only looked at in CAPTURE, after SETTLE, so they are static.
   assign cmp_gt = (count_a > count_b);
   assign cmp_eq = (count_a == count_b);

   always_comb begin
`ifdef PUF_MAJORITY_EN
      votes     = ones_reg + {1'b0, cmp_gt};
      pair_done = (rep_reg == 2'(MAJ_RUNS - 1));
      pair_bit  = votes[1];   // at least 2 of 3 runs said a>b
`else
      pair_done = 1'b1;
      pair_bit  = cmp_gt;
`endif
      last_capture = pair_done && (pair_reg == IW'(RESP_BITS - 1));
   end

   // Timer is loaded on the same edge that enters the timed state.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(CLR_CYC);
            end
         end
         ST_CLEAR: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(WIN_CYCLES);
            end
         end
         ST_RUN: begin
            if (tmr_tc) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(SETTLE_CYC);
            end
         end
         ST_CAPTURE: begin
            if (!last_capture) begin
               tmr_load = 1'b1;
               tmr_val  = TW'(CLR_CYC);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_reg      <= ST_IDLE;
         pair_reg       <= '0;
         resp_sr_reg    <= '0;
         resp_reg       <= '0;
         chal_a_reg     <= '0;
         chal_b_reg     <= '0;
         osc_en_reg     <= 1'b0;
         cnt_clr_reg    <= 1'b0;
         busy_reg       <= 1'b0;
         resp_valid_reg <= 1'b0;
         tie_seen_reg   <= 1'b0;
`ifdef PUF_MAJORITY_EN
         rep_reg        <= '0;
         ones_reg       <= '0;
`endif
      end else begin
         resp_valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg    <= ST_CLEAR;
                  cnt_clr_reg  <= 1'b1;
                  busy_reg     <= 1'b1;
                  chal_a_reg   <= chal_base;
                  chal_b_reg   <= chal_base + CHAL_W'(1);
                  pair_reg     <= '0;
                  resp_sr_reg  <= '0;
                  tie_seen_reg <= 1'b0;
`ifdef PUF_MAJORITY_EN
                  rep_reg      <= '0;
                  ones_reg     <= '0;
`endif
               end
            end
            ST_CLEAR: begin
               if (tmr_tc) begin
                  state_reg   <= ST_RUN;
                  cnt_clr_reg <= 1'b0;
                  osc_en_reg  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (tmr_tc) begin
                  state_reg  <= ST_SETTLE;
                  osc_en_reg <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (tmr_tc) begin
                  state_reg <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (cmp_eq) begin
                  tie_seen_reg <= 1'b1;
               end
`ifdef PUF_MAJORITY_EN
               if (pair_done) begin
                  rep_reg  <= '0;
                  ones_reg <= '0;
               end else begin
                  rep_reg  <= rep_reg + 2'd1;
                  ones_reg <= votes;
               end
`endif
               if (pair_done) begin
                  resp_sr_reg <= (resp_sr_reg << 1) | RESP_BITS'(pair_bit);
                  pair_reg    <= pair_reg + IW'(1);
               end
               if (last_capture) begin
                  state_reg <= ST_DONE;
               end else begin
                  state_reg   <= ST_CLEAR;
                  cnt_clr_reg <= 1'b1;
                  // Selects move to the next pair only once the pair is finished.
                  if (pair_done) begin
                     chal_a_reg <= chal_a_reg + CHAL_W'(2);
                     chal_b_reg <= chal_b_reg + CHAL_W'(2);
                  end
               end
            end
            ST_DONE: begin
               state_reg      <= ST_IDLE;
               resp_reg       <= resp_sr_reg;
               resp_valid_reg <= 1'b1;
               busy_reg       <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign osc_en     = osc_en_reg;
   assign cnt_clr    = cnt_clr_reg;
   assign chal_a     = chal_a_reg;
   assign chal_b     = chal_b_reg;
   assign busy       = busy_reg;
   assign resp       = resp_reg;
   assign resp_valid = resp_valid_reg;
   assign tie_seen   = tie_seen_reg;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl -- scoreboard bench for puf_eval_ctrl (WIN_CYCLES=16,
// RESP_BITS=4). The oscillator banks are modelled by a per-oscillator count
// table indexed by chal_a/chal_b, so a wrong select also shows up as a wrong
// response bit. Expected responses, tie flags, due cycles and select
// sequences are pushed when start is issued; a monitor pops and compares.
module tb_puf_eval_ctrl;

   localparam int CNT_W  = 16;
   localparam int CHAL_W = 4;
   localparam int RB     = 4;
   localparam int WIN    = 16;
`ifdef PUF_MAJORITY_EN
   localparam int RUNS   = 3;
`else
   localparam int RUNS   = 1;
`endif
   localparam int LAT    = RB * RUNS * (WIN + 7) + 1;

   typedef struct {
      logic [RB-1:0] resp;
      logic          tie;
      int            due;
   } exp_t;

   typedef struct {
      logic [CHAL_W-1:0] a;
      logic [CHAL_W-1:0] b;
   } chal_t;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CHAL_W-1:0] chal_base;
   logic [CNT_W-1:0]  count_a;
   logic [CNT_W-1:0]  count_b;
   logic              osc_en;
   logic              cnt_clr;
   logic [CHAL_W-1:0] chal_a;
   logic [CHAL_W-1:0] chal_b;
   logic              busy;
   logic [RB-1:0]     resp;
   logic              resp_valid;
   logic              tie_seen;

   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;
   exp_t  sb_q[$];
   chal_t chal_q[$];

   logic [CNT_W-1:0] freq [16];
   logic [2:0]       maj_pat [4];   // bit r = a>b result of run r for that pair
   logic             maj_mode;
   int               clr_total = 0; // written only by the monitor
   int               clr_base  = 0; // written only by the driver
   int               osc_run   = 0;
   logic             clr_prev  = 1'b0;

   puf_eval_ctrl #(
      .CNT_W      (CNT_W),
      .CHAL_W     (CHAL_W),
      .RESP_BITS  (RB),
      .WIN_CYCLES (WIN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .chal_base  (chal_base),
      .count_a    (count_a),
      .count_b    (count_b),
      .osc_en     (osc_en),
      .cnt_clr    (cnt_clr),
      .chal_a     (chal_a),
      .chal_b     (chal_b),
      .busy       (busy),
      .resp       (resp),
      .resp_valid (resp_valid),
      .tie_seen   (tie_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: each oscillator has a fixed count; majority mode instead
   // plays back a per-run result pattern.
   always_comb begin
      count_a = freq[chal_a];
      count_b = freq[chal_b];
      if (maj_mode && (clr_total > clr_base) && (clr_total - clr_base <= 12)) begin
         count_b = 16'd1;
         count_a = maj_pat[(clr_total - clr_base - 1) / 3][(clr_total - clr_base - 1) % 3] ? 16'd2 : 16'd1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic clear_freq();
      for (int k = 0; k < 16; k++) freq[k] = 16'd0;
   endtask

   // Push the expected outcome of an evaluation accepted on the next edge.
   task automatic push_exp(input logic [CHAL_W-1:0] base, input logic [RB-1:0] r, input logic t);
      exp_t  e;
      chal_t c;
      e.resp = r;
      e.tie  = t;
      e.due  = cyc + 1 + LAT;
      sb_q.push_back(e);
      for (int p = 0; p < RB; p++) begin
         for (int n = 0; n < RUNS; n++) begin
            c.a = base + CHAL_W'(2 * p);
            c.b = base + CHAL_W'(2 * p + 1);
            chal_q.push_back(c);
         end
      end
      clr_base = clr_total;
      $display("issue base=%h expect resp=%b tie=%0d at cycle %0d", base, r, t, e.due);
   endtask

   task automatic issue(input logic [CHAL_W-1:0] base, input logic [RB-1:0] r, input logic t, input bit hold);
      @(negedge clk);
      chal_base = base;
      start     = 1'b1;
      push_exp(base, r, t);
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
         chk("busy_after_start", busy, 1'b1);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 4 * LAT) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         chk("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
         chal_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pops expectations when the DUT presents results.
   always @(negedge clk) begin
      exp_t  e;
      chal_t c;
      if (rst_n) begin
         osc_run  = 0;
         clr_prev = 1'b0;
      end else begin
         if (osc_en && cnt_clr) chk("osc_clr_overlap", 1'b1, 1'b0);
         if (osc_en) begin
            osc_run++;
         end else if (osc_run != 0) begin
            chk("osc_window_len", osc_run, WIN);
            osc_run = 0;
         end
         if (cnt_clr && !clr_prev) begin
            clr_total++;
            if (chal_q.size() == 0) begin
               chk("chal_unexpected_clear", 1'b1, 1'b0);
            end else begin
               c = chal_q.pop_front();
               chk("chal_a", chal_a, c.a);
               chk("chal_b", chal_b, c.b);
            end
         end
         clr_prev = cnt_clr;
         if (resp_valid) begin
            if (sb_q.size() == 0) begin
               chk("resp_valid_unexpected", 1'b1, 1'b0);
            end else begin
               e = sb_q.pop_front();
               $display("result resp=%b tie=%0d cycle=%0d", resp, tie_seen, cyc);
               chk("resp", resp, e.resp);
               chk("tie_seen", tie_seen, e.tie);
               chk("latency_cycle", cyc, e.due);
               chk("busy_at_valid", busy, 1'b0);
            end
         end
      end
   end

   initial begin
      int n;
      rst_n     = 1'b1;
      start     = 1'b0;
      chal_base = '0;
      maj_mode  = 1'b0;
      maj_pat[0] = 3'b101;   // 1,0,1 -> 1
      maj_pat[1] = 3'b100;   // 0,0,1 -> 0
      maj_pat[2] = 3'b011;   // 1,1,0 -> 1
      maj_pat[3] = 3'b010;   // 0,1,0 -> 0
      clear_freq();

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_osc_en", osc_en, 1'b0);
      chk("rst_cnt_clr", cnt_clr, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_tie_seen", tie_seen, 1'b0);
      chk("rst_resp", resp, '0);
      chk("rst_chal_a", chal_a, '0);
      chk("rst_chal_b", chal_b, '0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Tie on pair 1 (0x0100 == 0x0100): 0,0,1,1
      clear_freq();
      freq[0] = 16'd1;     freq[1] = 16'd2;
      freq[2] = 16'h0100;  freq[3] = 16'h0100;
      freq[4] = 16'd3;     freq[5] = 16'd1;
      freq[6] = 16'd5;     freq[7] = 16'd4;
      issue(4'h0, 4'b0011, 1'b1, 0);
      drain();

      // a>b on pairs 0 and 2 only -> 1010; tie flag cleared; start pulse mid-RUN ignored
      clear_freq();
      freq[0] = 16'd300;   freq[1] = 16'd200;
      freq[2] = 16'd100;   freq[3] = 16'd150;
      freq[4] = 16'd500;   freq[5] = 16'd499;
      freq[6] = 16'd10;    freq[7] = 16'd11;
      issue(4'h0, 4'b1010, 1'b0, 0);
      repeat (10) @(negedge clk);
      chk("osc_en_in_run", osc_en, 1'b1);
      start     = 1'b1;
      chal_base = 4'h7;
      @(negedge clk);
      start = 1'b0;
      drain();
      repeat (5) @(negedge clk);
      chk("start_ignored_busy", busy, 1'b0);
      chk("resp_held", resp, 4'b1010);

      // Wrap: E/F, 0/1, 2/3, 4/5 -> 1,0,1,1
      clear_freq();
      freq[14] = 16'd1000; freq[15] = 16'd2;
      freq[0]  = 16'd3;    freq[1]  = 16'd4;
      freq[2]  = 16'd9;    freq[3]  = 16'd8;
      freq[4]  = 16'd9;    freq[5]  = 16'd8;
      issue(4'hE, 4'b1011, 1'b0, 0);
      drain();

      // start held through DONE -> second evaluation accepted the cycle after DONE
      issue(4'hE, 4'b1011, 1'b0, 1);
      n = 0;
      while (!resp_valid && n < LAT + 10) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_valid_seen", resp_valid, 1'b1);
      push_exp(4'hE, 4'b1011, 1'b0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy_restart", busy, 1'b1);
      drain();

      // Reset mid-RUN
      clear_freq();
      freq[0] = 16'd300;   freq[1] = 16'd200;
      freq[2] = 16'd100;   freq[3] = 16'd150;
      freq[4] = 16'd500;   freq[5] = 16'd499;
      freq[6] = 16'd10;    freq[7] = 16'd11;
      issue(4'h3, 4'b0000, 1'b0, 0);
      n = 0;
      while (!osc_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk("pre_reset_osc_en", osc_en, 1'b1);
      #2;
      rst_n = 1'b1;
      #1;
      chk("async_reset_osc_en", osc_en, 1'b0);
      chk("async_reset_busy", busy, 1'b0);
      sb_q.delete();
      chal_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("post_reset_resp", resp, '0);
      chk("post_reset_busy", busy, 1'b0);
      chk("post_reset_tie", tie_seen, 1'b0);
      issue(4'h0, 4'b1010, 1'b0, 0);
      drain();

`ifdef PUF_MAJORITY_EN
      // Majority: per-run patterns give 1,0,1,0
      maj_mode = 1'b1;
      issue(4'h0, 4'b1010, 1'b0, 0);
      drain();
      maj_mode = 1'b0;
`endif

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
